// File: rtl/cmd_desc_loader.sv
// Command descriptor loader: writes an 8-byte descriptor into the regfile through the
// configuration port, then hands the regfile to the I3C controller and waits for completion.
module cmd_desc_loader #(
    parameter logic [11:0] CONFIG_LOCATION = 12'd1000,
    parameter int unsigned WR_GAP          = 2,
    parameter int unsigned TIMEOUT         = 50000
) (
    input  logic        i_sdr_clk,
    input  logic        i_sdr_rst,
    input  logic        i_desc_valid,
    output logic        o_desc_ready,
    input  logic [2:0]  i_cmd_attr,
    input  logic [3:0]  i_tid,
    input  logic [7:0]  i_cmd,
    input  logic        i_cp,
    input  logic [4:0]  i_dev_index,
    input  logic [2:0]  i_dtt,
    input  logic [2:0]  i_mode,
    input  logic        i_rnw,
    input  logic        i_wroc,
    input  logic        i_toc,
    input  logic [31:0] i_data,
    input  logic        i_abort,
    input  logic        i_ctrl_done,
    output logic [7:0]  o_regf_config,
    output logic [11:0] o_regf_wr_address_config,
    output logic        o_regf_wr_en_config,
    output logic        o_data_config_mux_sel,
    output logic        o_controller_en,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout
);

    typedef enum logic [2:0] {StIdle, StLoad, StSwitch, StRun, StDone} state_e;

    localparam logic [3:0]  GapLast = 4'(WR_GAP - 1);
    localparam logic [31:0] RunLast = 32'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [63:0] desc_q, desc_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic        done_d, timeout_d;
    logic [7:0]  cur_byte;
    logic [11:0] cur_addr;

    always_comb begin
        state_d   = state_q;
        desc_d    = desc_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        run_cnt_d = run_cnt_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_desc_valid && o_desc_ready) begin
                    // Descriptor is held already packed: byte k lives in desc[8k +: 8].
                    desc_d  = {i_data,
                               i_toc, i_wroc, i_rnw, i_mode, i_dtt[2:1],
                               i_dtt[0], 2'b00, i_dev_index,
                               i_cp, i_cmd[7:1],
                               i_cmd[0], i_tid, i_cmd_attr};
                    idx_d   = 3'd0;
                    gap_d   = 4'd0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (i_abort) begin
                    state_d = StIdle;
                end else if (gap_q == GapLast) begin
                    gap_d = 4'd0;
                    if (idx_q == 3'd7) state_d = StSwitch;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            StSwitch: begin
                if (i_abort) begin
                    state_d = StIdle;
                end else begin
                    state_d   = StRun;
                    run_cnt_d = 32'd0;
                end
            end
            StRun: begin
                // Abort beats completion, completion beats timeout.
                if (i_abort) begin
                    state_d = StIdle;
                end else if (i_ctrl_done) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (run_cnt_q == RunLast) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 32'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign cur_byte = desc_d[{idx_d, 3'b000} +: 8];
    assign cur_addr = CONFIG_LOCATION + {9'd0, idx_d};

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge i_sdr_clk) begin
        if (i_sdr_rst) begin
            state_q                  <= StIdle;
            desc_q                   <= 64'd0;
            idx_q                    <= 3'd0;
            gap_q                    <= 4'd0;
            run_cnt_q                <= 32'd0;
            o_desc_ready             <= 1'b0;
            o_busy                   <= 1'b0;
            o_regf_wr_en_config      <= 1'b0;
            o_regf_config            <= 8'h00;
            o_regf_wr_address_config <= 12'h000;
            o_data_config_mux_sel    <= 1'b1;
            o_controller_en          <= 1'b0;
            o_done                   <= 1'b0;
            o_timeout                <= 1'b0;
        end else begin
            state_q                  <= state_d;
            desc_q                   <= desc_d;
            idx_q                    <= idx_d;
            gap_q                    <= gap_d;
            run_cnt_q                <= run_cnt_d;
            o_desc_ready             <= (state_d == StIdle);
            o_busy                   <= (state_d != StIdle);
            o_regf_wr_en_config      <= (state_d == StLoad);
            o_regf_config            <= (state_d == StLoad) ? cur_byte : 8'h00;
            o_regf_wr_address_config <= (state_d == StLoad) ? cur_addr : 12'h000;
            o_data_config_mux_sel    <= !((state_d == StSwitch) || (state_d == StRun));
            o_controller_en          <= (state_d == StRun);
            o_done                   <= done_d;
            o_timeout                <= timeout_d;
        end
    end

endmodule

// File: tb/tb_cmd_desc_loader.sv
// Bench for cmd_desc_loader: two instances (default base / long timeout, and base 12'hFFE /
// TIMEOUT 20) driven in lockstep, with a write scoreboard plus directed checks.
module tb_cmd_desc_loader;

    localparam int unsigned GAP = 2;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [2:0]  cmd_attr;
    logic [3:0]  tid;
    logic [7:0]  cmd;
    logic        cp;
    logic [4:0]  dev_index;
    logic [2:0]  dtt;
    logic [2:0]  mode;
    logic        rnw, wroc, toc;
    logic [31:0] data;
    logic        abort, ctrl_done;

    logic        a_ready, a_wr_en, a_mux, a_ctrl_en, a_busy, a_done, a_timeout;
    logic [7:0]  a_cfg;
    logic [11:0] a_addr;
    logic        b_ready, b_wr_en, b_mux, b_ctrl_en, b_busy, b_done, b_timeout;
    logic [7:0]  b_cfg;
    logic [11:0] b_addr;

    int checks = 0;
    int errors = 0;
    logic [19:0] qa[$];
    logic [19:0] qb[$];
    logic [19:0] ent_a, ent_b;
    logic        any_pulse;

    cmd_desc_loader #(.CONFIG_LOCATION(12'd1000), .WR_GAP(GAP), .TIMEOUT(200)) dut_a (
        .i_sdr_clk(clk), .i_sdr_rst(rst), .i_desc_valid(valid), .o_desc_ready(a_ready),
        .i_cmd_attr(cmd_attr), .i_tid(tid), .i_cmd(cmd), .i_cp(cp), .i_dev_index(dev_index),
        .i_dtt(dtt), .i_mode(mode), .i_rnw(rnw), .i_wroc(wroc), .i_toc(toc), .i_data(data),
        .i_abort(abort), .i_ctrl_done(ctrl_done), .o_regf_config(a_cfg),
        .o_regf_wr_address_config(a_addr), .o_regf_wr_en_config(a_wr_en),
        .o_data_config_mux_sel(a_mux), .o_controller_en(a_ctrl_en), .o_busy(a_busy),
        .o_done(a_done), .o_timeout(a_timeout)
    );

    cmd_desc_loader #(.CONFIG_LOCATION(12'hFFE), .WR_GAP(GAP), .TIMEOUT(20)) dut_b (
        .i_sdr_clk(clk), .i_sdr_rst(rst), .i_desc_valid(valid), .o_desc_ready(b_ready),
        .i_cmd_attr(cmd_attr), .i_tid(tid), .i_cmd(cmd), .i_cp(cp), .i_dev_index(dev_index),
        .i_dtt(dtt), .i_mode(mode), .i_rnw(rnw), .i_wroc(wroc), .i_toc(toc), .i_data(data),
        .i_abort(abort), .i_ctrl_done(ctrl_done), .o_regf_config(b_cfg),
        .o_regf_wr_address_config(b_addr), .o_regf_wr_en_config(b_wr_en),
        .o_data_config_mux_sel(b_mux), .o_controller_en(b_ctrl_en), .o_busy(b_busy),
        .o_done(b_done), .o_timeout(b_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every regfile write cycle must match the next scoreboard entry {addr, data}.
    always @(negedge clk) begin
        if (a_wr_en) begin
            check("a_wr_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                ent_a = qa.pop_front();
                check("a_wr", 32'({a_addr, a_cfg}), 32'(ent_a));
            end
        end
        if (b_wr_en) begin
            check("b_wr_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                ent_b = qb.pop_front();
                check("b_wr", 32'({b_addr, b_cfg}), 32'(ent_b));
            end
        end
    end

    task automatic send_desc(input logic [2:0] f_attr, input logic [3:0] f_tid,
                             input logic [7:0] f_cmd, input logic f_cp, input logic [4:0] f_dev,
                             input logic [2:0] f_dtt, input logic [2:0] f_mode, input logic f_rnw,
                             input logic f_wroc, input logic f_toc, input logic [31:0] f_data);
        logic [7:0] bytes [8];
        int waited = 0;
        while (!(a_ready && b_ready) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("send_ready", 32'(a_ready && b_ready), 32'd1);
        cmd_attr = f_attr; tid = f_tid; cmd = f_cmd; cp = f_cp; dev_index = f_dev;
        dtt = f_dtt; mode = f_mode; rnw = f_rnw; wroc = f_wroc; toc = f_toc; data = f_data;
        valid = 1'b1;
        bytes[0] = {f_cmd[0], f_tid, f_attr};
        bytes[1] = {f_cp, f_cmd[7:1]};
        bytes[2] = {f_dtt[0], 2'b00, f_dev};
        bytes[3] = {f_toc, f_wroc, f_rnw, f_mode, f_dtt[2:1]};
        bytes[4] = f_data[7:0];
        bytes[5] = f_data[15:8];
        bytes[6] = f_data[23:16];
        bytes[7] = f_data[31:24];
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < int'(GAP); g++) begin
                qa.push_back({12'd1000 + 12'(k), bytes[k]});
                qb.push_back({12'hFFE + 12'(k), bytes[k]});
            end
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic check_reset();
        check("a_rst_vec", 32'({a_ready, a_wr_en, a_cfg, a_addr, a_mux, a_ctrl_en, a_busy,
                                a_done, a_timeout}), 32'h0000_0010);
        check("b_rst_vec", 32'({b_ready, b_wr_en, b_cfg, b_addr, b_mux, b_ctrl_en, b_busy,
                                b_done, b_timeout}), 32'h0000_0010);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; abort = 1'b0; ctrl_done = 1'b0;
        cmd_attr = '0; tid = '0; cmd = '0; cp = 1'b0; dev_index = '0; dtt = '0; mode = '0;
        rnw = 1'b0; wroc = 1'b0; toc = 1'b0; data = '0;
        tick(3);
        check_reset();
        rst = 1'b0;
        tick(1);
        check("ready_after_rst", 32'({a_ready, b_ready, a_busy}), 32'b110);

        // Reference descriptor; t counts negedges after the handshake edge.
        send_desc(3'd1, 4'd3, 8'h00, 1'b1, 5'd3, 3'd1, 3'd6, 1'b0, 1'b0, 1'b1, 32'h04030201);
        check("t0_byte0", 32'({a_addr, a_cfg}), 32'({12'd1000, 8'h19}));
        check("t0_flags", 32'({a_wr_en, a_mux, a_ready, a_busy}), 32'b1101);
        tick(4);
        check("wrap_byte2", 32'({b_addr, b_cfg}), 32'({12'h000, 8'h83}));
        tick(2);
        check("t6_byte3", 32'({a_addr, a_cfg}), 32'({12'd1003, 8'h98}));
        tick(10);
        check("switch", 32'({a_wr_en, a_mux, a_ctrl_en, a_busy}), 32'b0001);
        check("switch_q_empty", 32'(qa.size() + qb.size()), 32'd0);
        tick(1);
        check("run_entry", 32'({a_mux, a_ctrl_en, b_mux, b_ctrl_en}), 32'b0101);
        tick(19);
        check("b_pre_timeout", 32'({b_timeout, b_ctrl_en}), 32'b01);
        tick(1);
        check("b_timeout", 32'({b_timeout, b_done, b_ctrl_en, b_ready, a_ctrl_en}), 32'b10011);
        tick(1);
        check("b_timeout_pulse", 32'(b_timeout), 32'd0);
        tick(79);
        check("a_still_run", 32'({a_ctrl_en, a_timeout}), 32'b10);
        ctrl_done = 1'b1;
        tick(1);
        ctrl_done = 1'b0;
        check("a_done", 32'({a_done, a_ctrl_en, a_timeout, a_ready, a_busy}), 32'b10001);
        check("b_done_ignored", 32'(b_done), 32'd0);
        tick(1);
        check("a_done_pulse", 32'({a_done, a_ready, a_busy}), 32'b010);

        // Abort while byte 4 is being written.
        send_desc(3'd5, 4'hA, 8'hC3, 1'b0, 5'd17, 3'd6, 3'd2, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        tick(8);
        check("abort_byte4", 32'({a_addr, a_cfg}), 32'({12'd1004, 8'hEF}));
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_out", 32'({a_wr_en, a_mux, a_ctrl_en, a_ready, a_done, a_timeout}),
              32'b010100);
        check("abort_left", 32'(qa.size()), 32'd7);
        check("abort_left_b", 32'(qb.size()), 32'd7);
        qa.delete();
        qb.delete();
        abort = 1'b1;
        tick(2);
        abort = 1'b0;
        check("abort_idle_noeffect", 32'({a_ready, a_busy, a_wr_en}), 32'b100);

        // New descriptor after abort; valid while busy must be ignored. Done ties timeout.
        send_desc(3'd2, 4'd7, 8'h5A, 1'b1, 5'd31, 3'd4, 3'd5, 1'b1, 1'b0, 1'b1, 32'h89ABCDEF);
        valid = 1'b1; data = 32'h11111111; cmd = 8'hFF;
        tick(5);
        valid = 1'b0;
        tick(11);
        check("rewrite_q_empty", 32'(qa.size() + qb.size()), 32'd0);
        tick(20);
        ctrl_done = 1'b1;
        tick(1);
        ctrl_done = 1'b0;
        check("tie_done_wins", 32'({b_done, b_timeout, a_done}), 32'b101);
        tick(1);
        check("tie_after", 32'({b_ready, a_ready, b_timeout}), 32'b110);

        // Abort together with ctrl_done in RUN.
        send_desc(3'd0, 4'd1, 8'h81, 1'b0, 5'd9, 3'd2, 3'd1, 1'b0, 1'b1, 1'b1, 32'h55AA33CC);
        tick(20);
        abort = 1'b1; ctrl_done = 1'b1;
        tick(1);
        abort = 1'b0; ctrl_done = 1'b0;
        check("abort_done", 32'({a_done, a_timeout, b_done, b_timeout, a_ctrl_en, a_mux,
                                 a_ready}), 32'b0000011);
        any_pulse = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            any_pulse = any_pulse | b_timeout | b_done | a_done | a_timeout;
        end
        check("abort_no_pulse", 32'(any_pulse), 32'd0);

        // Synchronous reset in the middle of RUN.
        send_desc(3'd7, 4'd15, 8'hFF, 1'b1, 5'd0, 3'd7, 3'd7, 1'b1, 1'b1, 1'b1, 32'h0);
        tick(25);
        check("pre_rst_run", 32'({a_ctrl_en, b_ctrl_en}), 32'b11);
        rst = 1'b1;
        tick(1);
        check_reset();
        tick(1);
        rst = 1'b0;
        tick(1);
        check("post_rst_ready", 32'({a_ready, b_ready, a_busy, b_busy}), 32'b1100);
        any_pulse = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            any_pulse = any_pulse | b_timeout | a_wr_en | b_wr_en | a_ctrl_en;
        end
        check("post_rst_quiet", 32'(any_pulse), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
